// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow comes from b alone when a=0, or ripples through when a==b.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Results are published to the ports only once all bits are in, and held
// until the next accepted start.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dsh;     // result being assembled, MSB-in
  logic             r_br;      // running borrow
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;   // operand signs kept for the overflow rule
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bo;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_dsh   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_dsh <= {w_d, r_dsh[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= DONE;
        end
        DONE: begin
          // Publish the finished result; the pulse lands in the next cycle,
          // which is already IDLE so a back-to-back start can be taken.
          r_diff  <= r_dsh;
          r_bout  <= r_br;
          r_ovf   <= (r_a_msb != r_b_msb) && (r_dsh[WIDTH-1] != r_a_msb);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Called at a negedge; drives a start there and returns at the negedge
  // where done is seen. lat counts negedges from the start one (10 for W=8).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output int lat, output logic [7:0] d, output logic bo, output logic ov);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    lat = -1; d = '0; bo = 1'b0; ov = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
      if (done) begin
        lat = k; d = diff; bo = bout; ov = ovf;
        break;
      end
    end
  endtask

  task automatic vec(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int lat; logic [7:0] d; logic bo, ov;
    run_op(ta, tb, tbin, lat, d, bo, ov);
    chk({tag, "_lat"},  lat, 10);
    chk({tag, "_diff"}, d, ed);
    chk({tag, "_bout"}, bo, eb);
    chk({tag, "_ovf"},  ov, eo);
  endtask

  initial begin
    int lat, ndone, first;
    logic [7:0] d, ra, rb;
    logic bo, ov, rbin;
    logic [8:0] ref9;
    int s;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf",  ovf,  0);

    // start on the very first edge after reset release
    rst = 1'b0;
    vec("v5m3", 8'd5, 8'd3, 1'b0, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    chk("pulse_one_cycle", done, 0);
    chk("hold_diff", diff, 8'h02);
    chk("idle_busy", busy, 0);
    repeat (2) @(negedge clk);

    vec("v3m5",   8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, 1'b0);
    vec("v0m0b1", 8'd0,  8'd0,  1'b1, 8'hFF, 1'b1, 1'b0);
    vec("v80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    vec("v7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    @(negedge clk);

    // extra starts during RUN (edge 3) and DONE (edge 9) must be ignored
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    ndone = 0; first = 0; d = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9);
      a = 8'h55; b = 8'h0A; bin = 1'b1;
      if (done) begin
        ndone++;
        if (first == 0) begin first = k; d = diff; end
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_lat",   first, 10);
    chk("ign_diff",  d, 8'h0F);
    chk("ign_hold",  diff, 8'h0F);
    chk("ign_busy",  busy, 0);

    // reset in the middle of RUN discards the operation
    a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        chk("midrst_busy", busy, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
      end
      if (k == 4) rst = 1'b1;
      if (done) ndone++;
    end
    chk("midrst_nodone", ndone, 0);
    vec("after_rst", 8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0);

    // random back-to-back: each start lands in the done cycle of the last
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbin = 1'b1; end
      if (i == 1) begin ra = 8'h80; rb = 8'h00; rbin = 1'b1; end
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      run_op(ra, rb, rbin, lat, d, bo, ov);
      chk("rnd_spacing", lat, 10);
      chk("rnd_diff", d, ref9[7:0]);
      chk("rnd_bout", bo, ref9[8]);
      chk("rnd_ovf",  ov, (s > 127 || s < -128) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, minuend; captured on accepted start.
REQ-006 SHALL have port b, input, WIDTH, subtrahend; captured on accepted start.
REQ-007 SHALL have port bin, input, 1, borrow-in; captured on accepted start.
REQ-008 SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 SHALL have port diff, output, WIDTH, result a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1, final borrow-out (unsigned a < b + bin).
REQ-012 SHALL have port ovf, output, 1, signed two's-complement overflow of the subtraction.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH bit cycles, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL on accepted start load a and b into shift registers, borrow flop <= bin, bit counter <= 0.
REQ-015 SHALL in RUN process one bit per clock, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 SHALL shift the operand registers right by one and shift d into the MSB of the diff register each RUN cycle.
REQ-017 SHALL assert done exactly one cycle, beginning WIDTH+1 rising edges after the edge on which start was accepted.
REQ-018 SHALL present diff, bout, ovf valid from the done cycle and hold them stable until the next accepted start.
REQ-019 SHALL compute ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) using captured operand MSBs; bin does not alter this rule.
REQ-020 SHALL ignore start while busy is high (RUN or DONE); no restart, no operand recapture.
REQ-021 SHALL accept a start presented in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles per operation).
REQ-022 SHALL not alter diff/bout/ovf while shifting; intermediate diff register content SHALL NOT be driven to the diff port until done.
REQ-023 SHALL treat a, b, bin changes outside the accepting cycle as don't-care.

Reset
REQ-024 SHALL on rst high at a clock edge enter IDLE, clear busy, done, diff, bout, ovf, counter, borrow, and operand registers to 0.
REQ-025 SHALL have rst take priority over start and over an in-progress RUN; a reset mid-operation discards the partial result with no done pulse.
REQ-026 SHALL accept a start on the first edge after rst deasserts.

Structure
REQ-027 SHALL place state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH in a shared calculator package/include file.
REQ-028 SHALL instantiate one combinational sub-module full_subtractor (ports a, b, bin, d, bout) for the per-bit cell; control FSM and registers in serial_subtractor.
REQ-029 SHALL size the bit counter as clog2(WIDTH)+1 bits.

Verification
REQ-030 SHALL cover: WIDTH=8, a=5, b=3, bin=0 -> done at edge 9 after start, diff=8'h02, bout=0, ovf=0.
REQ-031 SHALL cover: a=3, b=5, bin=0 -> diff=8'hFE, bout=1, ovf=0; then a=0, b=0, bin=1 -> diff=8'hFF, bout=1.
REQ-032 SHALL cover: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1; a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1.
REQ-033 SHALL cover: start pulsed again at cycles 3 and 9 of an operation with different operands -> ignored, first result unchanged, single done pulse.
REQ-034 SHALL cover: rst asserted at RUN cycle 4 -> next cycle busy=0, diff=0, no done; new start after release yields correct result.
REQ-035 SHALL cover: exhaustive 8-bit random compare against a - b - bin reference model with back-to-back starts, checking done spacing of 10 cycles.
